// File: rtl/gemm_stim_driver_if.sv
// Tile/result bus between the GEMM stimulus driver and the array under test.
//   master (driver): drives A_out, B_out, bias_out, out_valid; samples out_ready,
//                    res_valid, res_data.
//   slave  (array) : the mirror image.
interface gemm_stim_driver_if #(
  parameter int M                 = 1,
  parameter int N                 = 1,
  parameter int K                 = 8,
  parameter int DATA_WIDTH_A      = 8,
  parameter int DATA_WIDTH_B      = 8,
  parameter int DATA_WIDTH_bias   = DATA_WIDTH_B,
  parameter int DATA_WIDTH_output = DATA_WIDTH_B
);
  logic [M*K*DATA_WIDTH_A-1:0]    A_out;
  logic [K*N*DATA_WIDTH_B-1:0]    B_out;
  logic [N*DATA_WIDTH_bias-1:0]   bias_out;
  logic                           out_valid;
  logic                           out_ready;
  logic                           res_valid;
  logic [N*DATA_WIDTH_output-1:0] res_data;

  modport master (
    output A_out, B_out, bias_out, out_valid,
    input  out_ready, res_valid, res_data
  );

  modport slave (
    input  A_out, B_out, bias_out, out_valid,
    output out_ready, res_valid, res_data
  );
endinterface

// File: rtl/gemm_stim_driver.sv
// Stimulus generator and result compactor for the GEMM array.
// Produces NUM_TILES operand tiles per run (LFSR / ramp / all-ones / hold-last)
// over a valid/ready handshake and folds every result vector into a 32-bit MISR.
//   clk, rst        : clock, synchronous active-high reset
//   start, mode     : run request pulse and generation mode (sampled on start)
//   bus             : tile outputs + handshake, result inputs (master side)
//   busy, done      : run in progress / run complete (sticky)
//   tile_cnt        : tiles accepted in the current run
//   signature       : MISR of absorbed results
//   res_count       : result vectors absorbed, saturating
module gemm_stim_driver #(
  parameter int          M                 = 1,
  parameter int          N                 = 1,
  parameter int          K                 = 8,
  parameter int          DATA_WIDTH_A      = 8,
  parameter int          DATA_WIDTH_B      = 8,
  parameter int          DATA_WIDTH_bias   = DATA_WIDTH_B,
  parameter int          DATA_WIDTH_output = DATA_WIDTH_B,
  parameter int          UPDATE_PERIOD     = M*DATA_WIDTH_A,
  parameter int          NUM_TILES         = 16,
  parameter logic [15:0] SEED_A            = 16'hA5,
  parameter logic [15:0] SEED_B            = 16'h5A,
  parameter logic [15:0] SEED_bias         = 16'hC3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  mode,
  gemm_stim_driver_if.master bus,
  output logic        busy,
  output logic        done,
  output logic [15:0] tile_cnt,
  output logic [31:0] signature,
  output logic [15:0] res_count
);
  localparam int unsigned NA    = M*K;
  localparam int unsigned NB    = K*N;
  localparam int unsigned DWA   = DATA_WIDTH_A;
  localparam int unsigned DWB   = DATA_WIDTH_B;
  localparam int unsigned DWC   = DATA_WIDTH_bias;
  localparam int unsigned DWO   = DATA_WIDTH_output;
  localparam int unsigned GAP_W = (UPDATE_PERIOD > 1) ? $clog2(UPDATE_PERIOD) : 1;

  localparam logic [1:0] MODE_LFSR = 2'd0;
  localparam logic [1:0] MODE_RAMP = 2'd1;
  localparam logic [1:0] MODE_ONES = 2'd2;

  typedef enum logic [2:0] {S_IDLE, S_GEN, S_VALID, S_GAP, S_DONE} state_t;

  state_t            r_state, w_next_state;
  logic              w_start_ok, w_accept, w_last;
  logic [1:0]        r_mode;
  logic [GAP_W-1:0]  r_gap_cnt;
  logic [15:0]       r_lfsr_a [NA];
  logic [15:0]       r_lfsr_b [NB];
  logic [15:0]       r_lfsr_c [N];
  logic [15:0]       w_lfsr_a [NA];
  logic [15:0]       w_lfsr_b [NB];
  logic [15:0]       w_lfsr_c [N];
  logic [NA*DWA-1:0] w_a;
  logic [NB*DWB-1:0] w_b;
  logic [N*DWC-1:0]  w_c;
  logic [31:0]       w_fold;
  logic signed [DWO-1:0] w_res_elem;

  // Galois LFSR, right shift, taps 0xB400
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  // Per-lane seed; an all-zero lane would lock up, so it is forced to 1
  function automatic logic [15:0] lane_seed(input logic [15:0] base, input int unsigned idx);
    logic [15:0] v;
    v = base ^ 16'(idx);
    return (v == 16'h0000) ? 16'h0001 : v;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state and handshake decode
  always_comb begin
    w_next_state = r_state;
    w_start_ok   = 1'b0;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        w_next_state = S_IDLE;
        if (start) begin
          w_start_ok   = 1'b1;
          w_next_state = S_GEN;
        end
      end
      S_GEN:   w_next_state = S_VALID;
      S_VALID: begin
        if (bus.out_ready) begin
          w_accept     = 1'b1;
          w_last       = (tile_cnt == 16'(NUM_TILES - 1));
          w_next_state = w_last ? S_DONE : S_GAP;
        end
      end
      S_GAP:   if (r_gap_cnt == GAP_W'(UPDATE_PERIOD - 1)) w_next_state = S_GEN;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Candidate tile; hold-last falls through to the current registers
  always_comb begin
    w_a = bus.A_out;
    w_b = bus.B_out;
    w_c = bus.bias_out;
    for (int i = 0; i < int'(NA); i++) begin
      w_lfsr_a[i] = lfsr_step(r_lfsr_a[i]);
      case (r_mode)
        MODE_LFSR: w_a[i*DWA +: DWA] = DWA'(w_lfsr_a[i]);
        MODE_RAMP: w_a[i*DWA +: DWA] = DWA'(tile_cnt + 16'(i));
        MODE_ONES: w_a[i*DWA +: DWA] = DWA'(1);
        default:   ;
      endcase
    end
    for (int i = 0; i < int'(NB); i++) begin
      w_lfsr_b[i] = lfsr_step(r_lfsr_b[i]);
      case (r_mode)
        MODE_LFSR: w_b[i*DWB +: DWB] = DWB'(w_lfsr_b[i]);
        MODE_RAMP: w_b[i*DWB +: DWB] = DWB'(tile_cnt + 16'(i));
        MODE_ONES: w_b[i*DWB +: DWB] = DWB'(1);
        default:   ;
      endcase
    end
    for (int i = 0; i < N; i++) begin
      w_lfsr_c[i] = lfsr_step(r_lfsr_c[i]);
      case (r_mode)
        MODE_LFSR: w_c[i*DWC +: DWC] = DWC'(w_lfsr_c[i]);
        MODE_RAMP: w_c[i*DWC +: DWC] = DWC'(tile_cnt + 16'(i));
        MODE_ONES: w_c[i*DWC +: DWC] = DWC'(1);
        default:   ;
      endcase
    end
  end

  // XOR of sign-extended result elements
  always_comb begin
    w_fold     = '0;
    w_res_elem = '0;
    for (int n = 0; n < N; n++) begin
      w_res_elem = bus.res_data[n*DWO +: DWO];
      w_fold     = w_fold ^ 32'(w_res_elem);
    end
  end

  // Registered outputs, LFSR lanes and MISR
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.A_out     <= '0;
      bus.B_out     <= '0;
      bus.bias_out  <= '0;
      bus.out_valid <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      tile_cnt      <= '0;
      res_count     <= '0;
      signature     <= 32'hFFFF_FFFF;
      r_mode        <= MODE_LFSR;
      r_gap_cnt     <= '0;
      for (int i = 0; i < int'(NA); i++) r_lfsr_a[i] <= lane_seed(SEED_A, i);
      for (int i = 0; i < int'(NB); i++) r_lfsr_b[i] <= lane_seed(SEED_B, i);
      for (int i = 0; i < N; i++)        r_lfsr_c[i] <= lane_seed(SEED_bias, i);
    end else begin
      busy          <= (w_next_state == S_GEN) || (w_next_state == S_VALID) ||
                       (w_next_state == S_GAP);
      bus.out_valid <= (w_next_state == S_VALID);
      r_gap_cnt     <= (r_state == S_GAP) ? r_gap_cnt + GAP_W'(1) : '0;

      if (w_start_ok) begin
        done     <= 1'b0;
        tile_cnt <= '0;
        r_mode   <= mode;
      end
      if (w_accept) tile_cnt <= tile_cnt + 16'd1;
      if (w_accept && w_last) done <= 1'b1;

      if (r_state == S_GEN) begin
        bus.A_out    <= w_a;
        bus.B_out    <= w_b;
        bus.bias_out <= w_c;
        if (r_mode == MODE_LFSR) begin
          r_lfsr_a <= w_lfsr_a;
          r_lfsr_b <= w_lfsr_b;
          r_lfsr_c <= w_lfsr_c;
        end
      end

      // A start in the same cycle as a result clears and drops that result
      if (w_start_ok) begin
        signature <= 32'hFFFF_FFFF;
        res_count <= '0;
      end else if (bus.res_valid) begin
        signature <= {signature[30:0],
                      signature[31] ^ signature[21] ^ signature[1] ^ signature[0]} ^ w_fold;
        if (res_count != 16'hFFFF) res_count <= res_count + 16'd1;
      end
    end
  end
endmodule
